// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: valid/ready beat stream carrying ROM words.
// master drives valid/data/addr/last and samples ready; slave is the sink.
interface rom_burst_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: pattern ROM streaming a burst of consecutive words.
// Ports: clk, rst_n, start/start_addr/burst_len command, busy, done,
//        out_if (master): out_valid/out_ready/out_data/out_addr/out_last.
module rom_burst_reader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int LEN_W   = 5,
    parameter int PATTERN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    rom_burst_reader_if.master out_if
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    // Word content for address a; DEPTH may exceed DATA_W, hence the mod.
    function automatic logic [DATA_W-1:0] rom_word(int a);
        logic [DATA_W-1:0] w;
        int                b;
        w = '0;
        b = a % DATA_W;
        if (PATTERN == 0) begin
            w[b] = 1'b1;
        end else if (PATTERN == 1) begin
            for (int i = 0; i < DATA_W; i++) begin
                w[i] = (i <= b);
            end
        end else begin
            w = DATA_W'(a);
        end
        return w;
    endfunction

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = rom_word(g);
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] nxt_addr;

    // Natural ADDR_W overflow gives the DEPTH-1 -> 0 wrap.
    assign nxt_addr = addr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d = STREAM;
                        addr_d  = start_addr;
                        rem_d   = burst_len;
                        data_d  = rom[start_addr];
                        last_d  = (burst_len == LEN_W'(1));
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_if.out_ready) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        rem_d   = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = nxt_addr;
                        rem_d  = rem_q - 1'b1;
                        data_d = rom[nxt_addr];
                        last_d = (rem_q == LEN_W'(2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_valid = (state_q == STREAM);
    assign out_if.out_data  = data_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state_q == STREAM);
    assign done             = done_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: four ROM variants on shared stimulus,
// checked cycle by cycle against a burst-level reference model.
module tb_rom_burst_reader;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] start_addr;
    logic [4:0] burst_len;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;

    rom_burst_reader_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
    rom_burst_reader_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
    rom_burst_reader_if #(.DATA_W(16), .ADDR_W(4)) if2 ();
    rom_burst_reader_if #(.DATA_W(16), .ADDR_W(5)) if3 ();

    logic busy_w [4];
    logic done_w [4];

    assign if0.out_ready = ready;
    assign if1.out_ready = ready;
    assign if2.out_ready = ready;
    assign if3.out_ready = ready;

    rom_burst_reader #(.DATA_W(16), .ADDR_W(4), .LEN_W(5), .PATTERN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr[3:0]), .burst_len(burst_len),
        .busy(busy_w[0]), .done(done_w[0]), .out_if(if0));
    rom_burst_reader #(.DATA_W(16), .ADDR_W(4), .LEN_W(5), .PATTERN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr[3:0]), .burst_len(burst_len),
        .busy(busy_w[1]), .done(done_w[1]), .out_if(if1));
    rom_burst_reader #(.DATA_W(16), .ADDR_W(4), .LEN_W(5), .PATTERN(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr[3:0]), .burst_len(burst_len),
        .busy(busy_w[2]), .done(done_w[2]), .out_if(if2));
    rom_burst_reader #(.DATA_W(16), .ADDR_W(5), .LEN_W(5), .PATTERN(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr), .burst_len(burst_len),
        .busy(busy_w[3]), .done(done_w[3]), .out_if(if3));

    logic        v [4];
    logic        l [4];
    logic [15:0] dat [4];
    logic [4:0]  adr [4];

    assign v[0] = if0.out_valid;
    assign v[1] = if1.out_valid;
    assign v[2] = if2.out_valid;
    assign v[3] = if3.out_valid;
    assign l[0] = if0.out_last;
    assign l[1] = if1.out_last;
    assign l[2] = if2.out_last;
    assign l[3] = if3.out_last;
    assign dat[0] = if0.out_data;
    assign dat[1] = if1.out_data;
    assign dat[2] = if2.out_data;
    assign dat[3] = if3.out_data;
    assign adr[0] = {1'b0, if0.out_addr};
    assign adr[1] = {1'b0, if1.out_addr};
    assign adr[2] = {1'b0, if2.out_addr};
    assign adr[3] = if3.out_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one burst = base address, length, beats taken.
    int pat [4] = '{0, 1, 2, 0};
    int dep [4] = '{16, 16, 16, 32};
    bit m_act;
    int m_base;
    int m_len;
    int m_idx;
    bit m_done;
    int beats;

    function automatic logic [15:0] rom_ref(int p, int a);
        int b;
        b = a % 16;
        if (p == 0) return 16'(1 << b);
        if (p == 1) return 16'((2 << b) - 1);
        return 16'(a);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int ea;
        for (int k = 0; k < 4; k++) begin
            ea = (m_base + m_idx) % dep[k];
            chk($sformatf("valid%0d", k), 32'(v[k]), 32'(m_act));
            chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m_act));
            chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(m_done));
            chk($sformatf("last%0d", k), 32'(l[k]),
                32'(m_act && (m_idx == m_len - 1)));
            if (m_act) begin
                chk($sformatf("addr%0d", k), 32'(adr[k]), 32'(ea));
                chk($sformatf("data%0d", k), 32'(dat[k]),
                    32'(rom_ref(pat[k], ea)));
            end
        end
    endtask

    task automatic rst_check();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(v[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
            chk($sformatf("rst_done%0d", k), 32'(done_w[k]), 32'd0);
            chk($sformatf("rst_last%0d", k), 32'(l[k]), 32'd0);
            chk($sformatf("rst_data%0d", k), 32'(dat[k]), 32'd0);
            chk($sformatf("rst_addr%0d", k), 32'(adr[k]), 32'd0);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_base = 0;
        m_len  = 0;
        m_idx  = 0;
        m_done = 1'b0;
    endtask

    task automatic model_edge(bit st, int sa, int ln, bit rdy);
        bit nd;
        nd = 1'b0;
        if (!m_act) begin
            if (st) begin
                if (ln != 0) begin
                    m_act  = 1'b1;
                    m_base = sa;
                    m_len  = ln;
                    m_idx  = 0;
                end else begin
                    nd = 1'b1;
                end
            end
        end else if (rdy) begin
            if (m_idx == m_len - 1) begin
                m_act = 1'b0;
                nd    = 1'b1;
            end else begin
                m_idx++;
            end
        end
        m_done = nd;
    endtask

    // Check the current cycle, drive the next one, advance the model.
    task automatic step(bit st, int sa, int ln, bit rdy);
        check_outputs();
        start      = st;
        start_addr = 5'(sa);
        burst_len  = 5'(ln);
        ready      = rdy;
        if (v[0] && rdy) beats++;
        model_edge(st, sa, ln, rdy);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        burst_len  = 5'd4;
        ready      = 1'b1;
        model_reset();
        beats = 0;

        repeat (3) begin
            start = ~start;
            @(negedge clk);
            rst_check();
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst from address 2
        beats = 0;
        step(1, 2, 4, 1);
        chk("p0_a2_first", 32'(dat[0]), 32'h0004);
        repeat (4) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("beats_basic", 32'(beats), 32'd4);

        // Wrap with backpressure on beat 2
        beats = 0;
        step(1, 14, 3, 1);
        chk("wrap_b1_data", 32'(dat[0]), 32'h4000);
        step(0, 0, 0, 1);
        chk("wrap_b2_data", 32'(dat[0]), 32'h8000);
        repeat (3) begin
            step(0, 0, 0, 0);
            chk("hold_data", 32'(dat[0]), 32'h8000);
            chk("hold_addr", 32'(adr[0]), 32'd15);
        end
        step(0, 0, 0, 1);
        chk("wrap_b3_data", 32'(dat[0]), 32'h0001);
        chk("wrap_b3_addr", 32'(adr[0]), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("beats_wrap", 32'(beats), 32'd3);

        // start held high mid-burst must not disturb it
        beats = 0;
        step(1, 5, 6, 1);
        repeat (6) step(1, 9, 2, 1);
        chk("beats_midstart", 32'(beats), 32'd6);
        // start in the done cycle is accepted
        step(1, 3, 1, 1);
        chk("p1_a3", 32'(dat[1]), 32'h000F);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Empty burst
        beats = 0;
        step(1, 7, 0, 1);
        step(0, 0, 0, 1);
        chk("beats_empty", 32'(beats), 32'd0);

        step(1, 9, 1, 1);
        chk("p2_a9", 32'(dat[2]), 32'h0009);
        step(0, 0, 0, 1);
        step(1, 17, 1, 0);
        chk("a5_a17_data", 32'(dat[3]), 32'h0002);
        chk("a5_a17_addr", 32'(adr[3]), 32'd17);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Burst longer than DEPTH
        step(1, 10, 20, 1);
        repeat (21) step(0, 0, 0, 1);

        // Randomized traffic
        repeat (600) begin
            int ln;
            ln = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                             : $urandom_range(0, 5);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 31), ln,
                 $urandom_range(0, 3) != 0);
        end
        repeat (40) step(0, 0, 0, 1);

        // Reset in the middle of a burst
        step(1, 4, 10, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        rst_check();
        model_reset();
        repeat (2) begin
            start = ~start;
            @(negedge clk);
            rst_check();
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        repeat (3) step(0, 0, 0, 1);
        step(1, 1, 2, 1);
        repeat (3) step(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
